// File: rtl/alu_seq_if.sv
// Valid/ready request and result channels of the sequential ALU.
// The master issues operations and consumes results. The slave is the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 64
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dst;

    modport master (
        output in_valid, alu_sel, src1, src2, out_ready,
        input  in_ready, out_valid, dst
    );

    modport slave (
        input  in_valid, alu_sel, src1, src2, out_ready,
        output in_ready, out_valid, dst
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-step ops register on accept,
// mul/mulhu/divu/remu iterate one bit per cycle for WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   io
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         op_reg;
    logic [WIDTH-1:0]   a_reg, b_reg, dst_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH:0]     rem_reg;
    logic [SHW-1:0]     cnt_reg;

    logic               in_ready, out_valid, accept, iterative;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   single_result, iter_result;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff, div_rem_next;
    logic [2*WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0]   div_q_next;
    logic               div_ge;

    assign shamt     = io.src2[SHW-1:0];
    assign iterative = (io.alu_sel >= 4'd10) && (io.alu_sel <= 4'd13);
    assign accept    = io.in_valid && in_ready;

    always_comb begin
        single_result = io.src1;
        case (io.alu_sel)
            4'd0:    single_result = io.src1 + io.src2;
            4'd1:    single_result = io.src1 - io.src2;
            4'd2:    single_result = io.src1 & io.src2;
            4'd3:    single_result = io.src1 | io.src2;
            4'd4:    single_result = io.src1 ^ io.src2;
            4'd5:    single_result = {{(WIDTH-1){1'b0}}, $signed(io.src1) < $signed(io.src2)};
            4'd6:    single_result = {{(WIDTH-1){1'b0}}, io.src1 < io.src2};
            4'd7:    single_result = io.src1 << shamt;
            4'd8:    single_result = io.src1 >> shamt;
            4'd9:    single_result = $unsigned($signed(io.src1) >>> shamt);
            default: single_result = io.src1;
        endcase
    end

    // Multiply: low half of acc holds the remaining multiplier bits,
    // high half accumulates the partial product and shifts right each step.
    assign mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
    assign mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide: low half of acc holds the dividend shifting out and quotient shifting in.
    // A zero divisor always "fits", giving all-ones quotient and remainder A.
    assign div_shift    = {rem_reg[WIDTH-1:0], acc_reg[WIDTH-1]};
    assign div_ge       = div_shift >= {1'b0, b_reg};
    assign div_diff     = div_shift - {1'b0, b_reg};
    assign div_rem_next = div_ge ? div_diff : div_shift;
    assign div_q_next   = {acc_reg[WIDTH-2:0], div_ge};

    always_comb begin
        iter_result = mul_acc_next[WIDTH-1:0];
        case ({op_reg[2], op_reg[0]})
            2'b00:   iter_result = mul_acc_next[WIDTH-1:0];
            2'b01:   iter_result = mul_acc_next[2*WIDTH-1:WIDTH];
            2'b10:   iter_result = div_q_next;
            default: iter_result = div_rem_next[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            IDLE, DONE: begin
                if (accept) begin
                    state_next = iterative ? BUSY : DONE;
                end else if (state_reg == DONE && io.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE) || (state_reg == DONE && io.out_ready);
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_reg  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            rem_reg <= '0;
            cnt_reg <= '0;
            dst_reg <= '0;
        end else if (accept) begin
            op_reg  <= io.alu_sel;
            a_reg   <= io.src1;
            b_reg   <= io.src2;
            rem_reg <= '0;
            cnt_reg <= SHW'(WIDTH - 1);
            acc_reg <= {{WIDTH{1'b0}}, io.alu_sel[2] ? io.src1 : io.src2};
            if (!iterative) begin
                dst_reg <= single_result;
            end
        end else if (state_reg == BUSY) begin
            cnt_reg <= cnt_reg - 1'b1;
            if (!op_reg[2]) begin
                acc_reg <= mul_acc_next;
            end else begin
                acc_reg <= {acc_reg[2*WIDTH-1:WIDTH], div_q_next};
                rem_reg <= div_rem_next;
            end
            if (cnt_reg == '0) begin
                dst_reg <= iter_result;
            end
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid;
    assign io.dst       = dst_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed table, stream/backpressure/abort
// sequences, and random operations against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_seq_if #(.WIDTH(W)) io ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .io(io));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] sel, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] prod;
        int sh;
        prod = {64'd0, a} * {64'd0, b};
        sh   = int'(b[5:0]);
        case (sel)
            4'd0:    model = a + b;
            4'd1:    model = a - b;
            4'd2:    model = a & b;
            4'd3:    model = a | b;
            4'd4:    model = a ^ b;
            4'd5:    model = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd6:    model = (a < b) ? 64'd1 : 64'd0;
            4'd7:    model = a << sh;
            4'd8:    model = a >> sh;
            4'd9:    model = $unsigned($signed(a) >>> sh);
            4'd10:   model = prod[63:0];
            4'd11:   model = prod[127:64];
            4'd12:   model = (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            4'd13:   model = (b == 64'd0) ? a : a % b;
            default: model = a;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] sel);
        return (sel >= 4'd10 && sel <= 4'd13) ? W + 1 : 1;
    endfunction

    // Called just after a negedge; returns just after a negedge.
    task automatic run_op(input logic [3:0] sel, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input string name);
        int n;
        int lat;
        logic ready_in_busy;
        io.alu_sel   = sel;
        io.src1      = a;
        io.src2      = b;
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        n = 0;
        while (!io.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({name, "_accept_timeout"}, 64'(n), 64'd0);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.alu_sel  = 4'($urandom);
        io.src1     = {$urandom, $urandom};
        io.src2     = {$urandom, $urandom};
        lat = 0;
        ready_in_busy = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!io.out_valid && io.in_ready) ready_in_busy = 1'b1;
        end while (!io.out_valid && lat < 200);
        check({name, "_latency"}, 64'(lat), 64'(lat_of(sel)));
        check({name, "_dst"}, io.dst, exp);
        check({name, "_in_ready_busy"}, 64'(ready_in_busy), 64'd0);
        $display("op %s sel=%0d a=%h b=%h dst=%h lat=%0d", name, sel, a, b, io.dst, lat);
        @(posedge clk);
        @(negedge clk);
        check({name, "_drained"}, 64'(io.out_valid), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        logic [63:0] held;
        logic [3:0] rs;
        logic [63:0] ra, rb;

        vecs[0]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,  64'd0};
        vecs[1]  = '{4'd9,  64'h8000_0000_0000_0000, 64'd68, 64'hF800_0000_0000_0000};
        vecs[2]  = '{4'd8,  64'h8000_0000_0000_0000, 64'd68, 64'h0800_0000_0000_0000};
        vecs[3]  = '{4'd7,  64'd1, 64'd63, 64'h8000_0000_0000_0000};
        vecs[4]  = '{4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[5]  = '{4'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
        vecs[6]  = '{4'd12, 64'd100, 64'd7, 64'd14};
        vecs[7]  = '{4'd13, 64'd100, 64'd7, 64'd2};
        vecs[8]  = '{4'd12, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9]  = '{4'd13, 64'd9, 64'd0, 64'd9};
        vecs[10] = '{4'd2,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000};
        vecs[11] = '{4'd3,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0};
        vecs[12] = '{4'd4,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0};
        vecs[13] = '{4'd14, 64'hDEAD_BEEF_0123_4567, 64'd5, 64'hDEAD_BEEF_0123_4567};
        vecs[14] = '{4'd15, 64'h0BAD_F00D_CAFE_0001, 64'd7, 64'h0BAD_F00D_CAFE_0001};
        vecs[15] = '{4'd5,  64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0};
        vecs[16] = '{4'd6,  64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1};

        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        io.alu_sel   = 4'd0;
        io.src1      = '0;
        io.src2      = '0;
        rst_n        = 1'b0;

        // Reset and idle
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", 64'(io.out_valid), 64'd0);
            check("rst_dst", io.dst, 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_in_ready", 64'(io.in_ready), 64'd1);
        check("idle_out_valid", 64'(io.out_valid), 64'd0);

        // Back-to-back single-step stream
        io.alu_sel = 4'd0; io.src1 = 64'd5; io.src2 = 64'd3; io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.alu_sel = 4'd1; io.src1 = 64'd3; io.src2 = 64'd5;
        @(negedge clk);
        check("stream_add_valid", 64'(io.out_valid), 64'd1);
        check("stream_add_dst", io.dst, 64'd8);
        check("stream_in_ready", 64'(io.in_ready), 64'd1);
        @(posedge clk);
        #1;
        io.alu_sel = 4'd5; io.src1 = 64'hFFFF_FFFF_FFFF_FFFF; io.src2 = 64'd1;
        @(negedge clk);
        check("stream_sub_dst", io.dst, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        @(negedge clk);
        check("stream_slt_dst", io.dst, 64'd1);
        $display("op stream add/sub/slt done dst=%h", io.dst);
        @(posedge clk);
        @(negedge clk);
        check("stream_drained", 64'(io.out_valid), 64'd0);

        // Directed table
        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while out_ready is low
        io.alu_sel = 4'd0; io.src1 = 64'd40; io.src2 = 64'd2; io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        io.src1 = 64'd999;
        seen = 1'b1;
        held = 64'd0;
        repeat (10) begin
            @(negedge clk);
            if (!io.out_valid || io.dst !== 64'd42) begin
                seen = 1'b0;
                held = io.dst;
            end
        end
        check("backpressure_hold", 64'(seen), 64'd1);
        if (!seen) $display("backpressure dst seen %h", held);
        check("backpressure_in_ready", 64'(io.in_ready), 64'd0);
        $display("op backpressure add dst=%h", io.dst);
        io.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("backpressure_release", 64'(io.out_valid), 64'd0);

        // Abort a multiply with reset mid-BUSY
        io.alu_sel = 4'd10; io.src1 = 64'd12345; io.src2 = 64'd678; io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (io.out_valid) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        $display("op abort mul out_valid_seen=%0d", seen);
        run_op(4'd0, 64'd1, 64'd1, 64'd2, "post_abort_add");

        // Random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 1000)) : {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = 64'd0;
                1:       rb = 64'($urandom_range(1, 70));
                default: rb = {$urandom, $urandom};
            endcase
            run_op(rs, ra, rb, model(rs, ra, rb), $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
